mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, external RAM address width.
REQ-002 SHALL have parameter DATA_W, default 4, RAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1, legal 1..3, cycles from mem_en sample to valid mem_rdata.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports cpu_req/cpu_we  in  1 each, cpu_addr  in  ADDR_W, cpu_wdata  in  DATA_W  CPU access request.
REQ-007 SHALL have ports cpu_gnt  out  1, cpu_rvalid  out  1, cpu_rdata  out  DATA_W  CPU grant and read return.
REQ-008 SHALL have ports dbg_req/dbg_we  in  1 each, dbg_addr  in  ADDR_W, dbg_wdata  in  DATA_W  loader/checker request.
REQ-009 SHALL have ports dbg_gnt  out  1, dbg_rvalid  out  1, dbg_rdata  out  DATA_W  debug grant and read return.
REQ-010 SHALL have ports dbg_halt  in  1 (fence CPU off bus) and halt_ack  out  1 (debug owns bus).
REQ-011 SHALL have ports mem_en/mem_we  out  1 each, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_rdata  in  DATA_W  single RAM port.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE; all outputs registered.
REQ-013 In IDLE, SHALL sample requests at each edge; eligible = dbg_req, plus cpu_req when dbg_halt=0.
REQ-014 Single eligible requester SHALL win; both eligible SHALL alternate round-robin via last_winner register.
REQ-015 Winner's addr/we/wdata SHALL be captured at the sampling edge; later changes to request inputs ignored until next IDLE.
REQ-016 In ACCESS (exactly 1 cycle): mem_en=1, mem_addr/mem_we/mem_wdata = captured values, winner's gnt=1; all gnt otherwise 0.
REQ-017 Write: ACCESS -> IDLE; requester may drop req in the gnt cycle; next grant no earlier than 2 cycles after previous gnt.
REQ-018 Read: ACCESS -> WAIT for RD_LAT cycles (counter), last WAIT edge captures mem_rdata into winner's rdata, -> DONE.
REQ-019 In DONE (1 cycle): winner's rvalid=1 with rdata stable; -> IDLE; rdata holds until next read for that port.
REQ-020 Read latency req-sampled edge to rvalid cycle SHALL be RD_LAT+2 cycles (3 at default).
REQ-021 mem_en, mem_we, gnt, rvalid SHALL be 0 outside states stated above; mem_addr/mem_wdata hold last value.
REQ-022 halt_ack SHALL be 1 iff dbg_halt=1 and no CPU transaction in ACCESS/WAIT/DONE; CPU transaction in flight when halt rises SHALL complete normally.
REQ-023 Request arriving same edge FSM leaves DONE/ACCESS-write SHALL not be sampled until IDLE; no request lost while req held.
REQ-024 Address 0x7FF and 0x000 SHALL be passed unmodified (no wrap or decode logic).

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, all outputs 0 (incl. mem_addr, mem_wdata, rdata), last_winner=DBG, WAIT counter 0.
REQ-026 Reset during WAIT/DONE SHALL abort the read; no rvalid emitted afterwards.
REQ-027 Requests held through reset SHALL be sampled at first edge with rst=0.

Verification
REQ-028 RAM[0x123]=0xA, cpu_req read 0x123 at edge E0 -> cpu_gnt and mem_addr=0x123, mem_we=0 in cycle 1; cpu_rvalid=1, cpu_rdata=0xA in cycle 3.
REQ-029 After reset, cpu_req and dbg_req both held (reads) -> CPU granted first, DBG next, then CPU; grants alternate.
REQ-030 dbg_halt=1, cpu_req held, dbg writes 0x7FF=0x5 -> cpu_gnt never 1, halt_ack=1, RAM[0x7FF]=0x5.
REQ-031 dbg_halt rises in CPU read ACCESS cycle -> cpu_rvalid still delivered; halt_ack=1 only from cycle after DONE.
REQ-032 rst pulsed during WAIT (RD_LAT=2) -> no rvalid, all outputs 0 next cycle, next request served normally.
REQ-033 cpu_req write held continuously, dbg idle -> cpu_gnt every 2nd cycle, mem_we=1 with captured data each ACCESS.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter onto a single synchronous RAM port.
// One transaction at a time; round-robin on contention, debug can fence the CPU off.
module mem_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 4,
   parameter int RD_LAT = 1   // legal 1..3
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,

   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,

   input  logic              dbg_halt,
   output logic              halt_ack,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

   state_t     state;
   logic       owner;      // 1 = debug owns the current transaction
   logic       last_dbg;   // 1 = debug won the previous arbitration
   logic       cur_we;
   logic [1:0] cnt;

   logic cpu_elig, dbg_elig, any_elig, pick_dbg, cpu_busy_nxt;

   always_comb begin
      cpu_elig = cpu_req & ~dbg_halt;
      dbg_elig = dbg_req;
      any_elig = cpu_elig | dbg_elig;
      pick_dbg = dbg_elig & (~cpu_elig | ~last_dbg);
   end

   // Whether a CPU transaction will occupy the bus in the next cycle; feeds halt_ack.
   always_comb begin
      cpu_busy_nxt = 1'b0;
      case (state)
         IDLE:    cpu_busy_nxt = any_elig & ~pick_dbg;
         ACCESS:  cpu_busy_nxt = ~cur_we & ~owner;
         WAIT:    cpu_busy_nxt = ~owner;
         DONE:    cpu_busy_nxt = 1'b0;
         default: cpu_busy_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_dbg   <= 1'b1;
         cur_we     <= 1'b0;
         cnt        <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_gnt    <= 1'b0;
         dbg_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rdata  <= '0;
         halt_ack   <= 1'b0;
      end else begin
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         cpu_gnt    <= 1'b0;
         dbg_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         halt_ack   <= dbg_halt & ~cpu_busy_nxt;

         case (state)
            IDLE: begin
               if (any_elig) begin
                  // mem_addr/mem_wdata double as the captured request.
                  owner     <= pick_dbg;
                  last_dbg  <= pick_dbg;
                  cur_we    <= pick_dbg ? dbg_we    : cpu_we;
                  mem_we    <= pick_dbg ? dbg_we    : cpu_we;
                  mem_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
                  mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
                  mem_en    <= 1'b1;
                  cpu_gnt   <= ~pick_dbg;
                  dbg_gnt   <= pick_dbg;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               cnt   <= '0;
               state <= cur_we ? IDLE : WAIT;
            end
            WAIT: begin
               if (cnt == CNT_LAST) begin
                  if (owner) begin
                     dbg_rdata  <= mem_rdata;
                     dbg_rvalid <= 1'b1;
                  end else begin
                     cpu_rdata  <= mem_rdata;
                     cpu_rvalid <= 1'b1;
                  end
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
